// File: rtl/keypad_entry_if.sv
// Handshake bundle between the keypad scanner, keypad_entry and the processor.
// The slave modport is the keypad_entry side; master is the scanner/processor side.
interface keypad_entry_if;
  logic        keyReady;
  logic [31:0] keyRow;
  logic [31:0] keyCol;
  logic        entryAck;
  logic        scanEnable;
  logic [31:0] entryValue;
  logic        entryValid;
  logic [3:0]  digitCount;
  logic        keyPulse;
  logic [3:0]  keyCode;

  modport master (
    output keyReady, keyRow, keyCol, entryAck,
    input  scanEnable, entryValue, entryValid, digitCount, keyPulse, keyCode
  );

  modport slave (
    input  keyReady, keyRow, keyCol, entryAck,
    output scanEnable, entryValue, entryValid, digitCount, keyPulse, keyCode
  );
endinterface

// File: rtl/keypad_entry.sv
// Decodes scanner key presses into a multi-digit decimal entry and hands it
// to the processor with a valid/ack handshake, gating the scanner meanwhile.
//
// state    | meaning
// ST_ENTRY | accepting keys, scanner enabled
// ST_DONE  | completed entry pending ack, scanner stopped, keys dropped
module keypad_entry #(
  parameter int MAX_DIGITS     = 6,
  parameter int HOLDOFF_CYCLES = 100000
) (
  input  logic          clock,
  input  logic          reset,
  keypad_entry_if.slave bus
);

  localparam int HOLD_BITS = ($clog2(HOLDOFF_CYCLES + 1) > 20) ? $clog2(HOLDOFF_CYCLES + 1) : 20;
  localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(HOLDOFF_CYCLES);
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);
  localparam logic [3:0] CODE_STAR = 4'd10;
  localparam logic [3:0] CODE_HASH = 4'd11;

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [HOLD_BITS-1:0] holdoff_q, holdoff_d;
  state_t               state_q, state_d;
  logic [31:0]          value_q, value_d;
  logic [3:0]           count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 scan_q, scan_d;
  logic                 pulse_q, pulse_d;
  logic [3:0]           code_q, code_d;

  logic                 key_rise;
  logic                 key_ok;
  logic                 accept;
  logic [3:0]           key_code;
  logic [31:0]          value_x10;

  always_comb begin
    key_rise = sync2_q & ~prev_q;
    key_ok   = (bus.keyRow < 32'd4) && (bus.keyCol < 32'd3);

    key_code = 4'd0;
    case ({bus.keyRow[1:0], bus.keyCol[1:0]})
      4'b00_00: key_code = 4'd1;
      4'b00_01: key_code = 4'd2;
      4'b00_10: key_code = 4'd3;
      4'b01_00: key_code = 4'd4;
      4'b01_01: key_code = 4'd5;
      4'b01_10: key_code = 4'd6;
      4'b10_00: key_code = 4'd7;
      4'b10_01: key_code = 4'd8;
      4'b10_10: key_code = 4'd9;
      4'b11_00: key_code = CODE_STAR;
      4'b11_01: key_code = 4'd0;
      4'b11_10: key_code = CODE_HASH;
      default:  key_code = 4'd0;
    endcase

    // Edges seen during holdoff or while an entry is pending are lost, not queued.
    accept    = key_rise && key_ok && (holdoff_q == '0) && (state_q == ST_ENTRY);
    value_x10 = (value_q << 3) + (value_q << 1);

    sync1_d   = bus.keyReady;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    value_d   = value_q;
    count_d   = count_q;
    pulse_d   = accept;
    code_d    = accept ? key_code : code_q;

    if (accept) begin
      holdoff_d = HOLD_LOAD;
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - HOLD_BITS'(1);
    end else begin
      holdoff_d = holdoff_q;
    end

    case (state_q)
      ST_ENTRY: begin
        if (accept) begin
          if (key_code == CODE_STAR) begin
            value_d = 32'd0;
            count_d = 4'd0;
          end else if (key_code == CODE_HASH) begin
            if (count_q != 4'd0) state_d = ST_DONE;
          end else if (count_q < MAX_CNT) begin
            value_d = value_x10 + {28'd0, key_code};
            count_d = count_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        if (bus.entryAck) begin
          state_d = ST_ENTRY;
          value_d = 32'd0;
          count_d = 4'd0;
        end
      end
      default: state_d = ST_ENTRY;
    endcase

    valid_d = (state_d == ST_DONE);
    scan_d  = (state_d == ST_ENTRY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      holdoff_q <= '0;
      state_q   <= ST_ENTRY;
      value_q   <= 32'd0;
      count_q   <= 4'd0;
      valid_q   <= 1'b0;
      scan_q    <= 1'b1;
      pulse_q   <= 1'b0;
      code_q    <= 4'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      holdoff_q <= holdoff_d;
      state_q   <= state_d;
      value_q   <= value_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      scan_q    <= scan_d;
      pulse_q   <= pulse_d;
      code_q    <= code_d;
    end
  end

  assign bus.scanEnable = scan_q;
  assign bus.entryValue = value_q;
  assign bus.entryValid = valid_q;
  assign bus.digitCount = count_q;
  assign bus.keyPulse   = pulse_q;
  assign bus.keyCode    = code_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed and random key sequences for keypad_entry, checked against a
// digit-list model that applies the keypad rules at each detection edge.
module tb_keypad_entry;
  localparam int H  = 4;
  localparam int MD = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  keypad_entry_if bus();

  keypad_entry #(.MAX_DIGITS(MD), .HOLDOFF_CYCLES(H)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int pulses = 0;
  always @(negedge clock) if (bus.keyPulse === 1'b1) pulses <= pulses + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: what the user has typed, by keypad rules.
  int     km [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
  longint m_val;
  int     m_cnt;
  bit     m_done;
  int     m_code;
  bit     m_pulse;
  int     last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " value"}, bus.entryValue, 32'(m_val));
    chk({tag, " count"}, {28'd0, bus.digitCount}, 32'(m_cnt));
    chk({tag, " valid"}, {31'd0, bus.entryValid}, {31'd0, m_done});
    chk({tag, " scan"},  {31'd0, bus.scanEnable}, {31'd0, !m_done});
    chk({tag, " pulse"}, {31'd0, bus.keyPulse},   {31'd0, m_pulse});
    chk({tag, " code"},  {28'd0, bus.keyCode},    32'(m_code));
  endtask

  task automatic model_reset();
    m_val = 0; m_cnt = 0; m_done = 0; m_code = 0; m_pulse = 0; last_acc = -100;
  endtask

  task automatic model_edge(input int r, input int c, input bit ack, input int now);
    m_pulse = 0;
    if (m_done) begin
      if (ack) begin
        m_done = 0; m_val = 0; m_cnt = 0;
      end
    end else if (r < 4 && c < 3 && (now - last_acc) > H) begin
      m_pulse  = 1;
      last_acc = now;
      m_code   = km[r][c];
      if (m_code < 10) begin
        if (m_cnt < MD) begin
          m_val = m_val * 10 + m_code;
          m_cnt++;
        end
      end else if (m_code == 10) begin
        m_val = 0; m_cnt = 0;
      end else if (m_cnt > 0) begin
        m_done = 1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  // keyReady rises at a negedge; the third following posedge is the detection edge.
  task automatic press(input int r, input int c, input int pre, input bit ack_too, input string tag);
    repeat (pre) @(negedge clock);
    bus.keyRow   = 32'(r);
    bus.keyCol   = 32'(c);
    bus.keyReady = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    bus.entryAck = ack_too;
    @(posedge clock);
    @(negedge clock);
    model_edge(r, c, ack_too, cyc);
    bus.entryAck = 1'b0;
    bus.keyReady = 1'b0;
    check_all(tag);
    m_pulse = 0;
    @(negedge clock);
    check_all({tag, "+1"});
  endtask

  task automatic do_ack(input int n);
    bus.entryAck = 1'b1;
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      if (m_done) begin
        m_done = 0; m_val = 0; m_cnt = 0;
      end
      check_all("ack");
    end
    bus.entryAck = 1'b0;
  endtask

  initial begin
    int p0;
    bus.keyReady = 1'b0;
    bus.keyRow   = 32'd0;
    bus.keyCol   = 32'd0;
    bus.entryAck = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    do_reset();

    // 1: 1,5,0,# -> 150 pending, then ack
    press(0, 0, 7, 1'b0, "t1_k1");
    press(1, 1, 7, 1'b0, "t1_k5");
    press(3, 1, 7, 1'b0, "t1_k0");
    press(3, 2, 7, 1'b0, "t1_hash");
    chk("t1 value150", bus.entryValue, 32'd150);
    do_ack(1);

    // 2: seven 9s then # saturate at six digits, eight strobes
    #1 p0 = pulses;
    for (int i = 0; i < 7; i++) press(2, 2, 2, 1'b0, "t2_k9");
    press(3, 2, 2, 1'b0, "t2_hash");
    chk("t2 value999999", bus.entryValue, 32'd999999);
    #1 chk("t2 pulse_cnt", 32'(pulses - p0), 32'd8);
    @(negedge clock);
    do_ack(2);
    press(3, 0, 2, 1'b0, "t2_star");

    // 3: holdoff drops a fast re-press, a later one is accepted
    press(1, 1, 2, 1'b0, "t3_k5");
    press(1, 1, 0, 1'b0, "t3_fast");
    press(1, 1, 5, 1'b0, "t3_slow");
    chk("t3 value55", bus.entryValue, 32'd55);

    // 4: keys dropped while pending; ack wins over a simultaneous key
    press(3, 2, 6, 1'b0, "t4_hash");
    press(2, 0, 6, 1'b0, "t4_k7_done");
    press(1, 0, 6, 1'b1, "t4_ack_key");

    // 5: invalid index starts no holdoff
    press(4, 0, 6, 1'b0, "t5_bad");
    press(0, 1, 1, 1'b0, "t5_k2");

    // 6: reset mid-entry, then lone #
    press(0, 0, 6, 1'b0, "t6_k1");
    press(0, 1, 6, 1'b0, "t6_k2");
    do_reset();
    press(3, 2, 2, 1'b0, "t6_hash");

    // Random key traffic with interleaved acks
    for (int i = 0; i < 60; i++) begin
      if (m_done && $urandom_range(0, 2) == 0) begin
        do_ack($urandom_range(1, 3));
      end else begin
        press($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 5),
              ($urandom_range(0, 7) == 0), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
